// File: rtl/bus_pkg.sv
// Shared types for the two-master memory bus arbiter: FSM states, master IDs,
// the latched request record and the grant encoding helper.
package bus_pkg;

  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    ACK  = 2'd2
  } arb_state_e;

  typedef enum logic {
    M0_CPU = 1'b0,
    M1_DMA = 1'b1
  } master_e;

  typedef struct packed {
    logic              wr;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } bus_req_t;

  function automatic logic [1:0] grant_onehot(input master_e m);
    return (m == M1_DMA) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Master-side, memory-side and status signals of the bus arbiter.
// The slave modport is the arbiter's view; master is the environment's view.
interface bus_arbiter_if;

  logic        m0_req;
  logic        m0_wr;
  logic [31:0] m0_addr;
  logic [31:0] m0_wdata;
  logic        m0_ack;
  logic        m0_err;
  logic [31:0] m0_rdata;

  logic        m1_req;
  logic        m1_wr;
  logic [31:0] m1_addr;
  logic [31:0] m1_wdata;
  logic        m1_ack;
  logic        m1_err;
  logic [31:0] m1_rdata;

  logic        mem_rd;
  logic        mem_wr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  logic [1:0]  grant;
  logic        busy;

  modport slave (
    input  m0_req, m0_wr, m0_addr, m0_wdata,
    input  m1_req, m1_wr, m1_addr, m1_wdata,
    input  mem_rdata, mem_ready,
    output m0_ack, m0_err, m0_rdata,
    output m1_ack, m1_err, m1_rdata,
    output mem_rd, mem_wr, mem_addr, mem_wdata,
    output grant, busy
  );

  modport master (
    output m0_req, m0_wr, m0_addr, m0_wdata,
    output m1_req, m1_wr, m1_addr, m1_wdata,
    output mem_rdata, mem_ready,
    input  m0_ack, m0_err, m0_rdata,
    input  m1_ack, m1_err, m1_rdata,
    input  mem_rd, mem_wr, mem_addr, mem_wdata,
    input  grant, busy
  );

endinterface

// File: rtl/bus_arb_pick.sv
// Winner selection with fixed M0 priority, bounded by a starvation streak
// counter so a waiting M1 wins after STREAK_MAX back-to-back M0 grants.
module bus_arb_pick
  import bus_pkg::*;
#(
  parameter int unsigned STREAK_MAX = 4
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    m0_req_i,
  input  logic    m1_req_i,
  input  logic    pick_en_i,
  output master_e winner_o
);

  localparam int unsigned SW = $clog2(STREAK_MAX + 1);

  logic [SW-1:0] streak_q, streak_d;
  master_e       winner_s;

  // Winner: lone requester wins; on contention M0 unless M1 has waited long enough
  always_comb begin
    winner_s = M0_CPU;
    if (m1_req_i && !m0_req_i) begin
      winner_s = M1_DMA;
    end else if (m1_req_i && m0_req_i && (streak_q == SW'(STREAK_MAX))) begin
      winner_s = M1_DMA;
    end else begin
      winner_s = M0_CPU;
    end
  end

  // Streak next-state: counts M0 wins that kept M1 waiting
  always_comb begin
    streak_d = streak_q;
    if (pick_en_i) begin
      if ((winner_s == M0_CPU) && m1_req_i) begin
        streak_d = (streak_q == SW'(STREAK_MAX)) ? streak_q : streak_q + SW'(1);
      end else begin
        streak_d = '0;
      end
    end else begin
      streak_d = streak_q;
    end
  end

  // Streak register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      streak_q <= '0;
    end else begin
      streak_q <= streak_d;
    end
  end

  assign winner_o = winner_s;

endmodule

// File: rtl/bus_arbiter.sv
// Two-master (CPU, DMA) single-memory bus arbiter: IDLE -> XFER -> ACK with
// request latching, wait-state timeout and one-cycle ack/err completion.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int unsigned STREAK_MAX = 4,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic          clk,
  input  logic          rst,
  bus_arbiter_if.slave  bus
);

  localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);

  arb_state_e        state_q, state_d;
  master_e           owner_q, owner_d;
  master_e           winner_s;
  bus_req_t          req_q, req_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [1:0]        grant_q, grant_d;
  logic              pick_en_s;
  logic              in_xfer_s;
  logic              in_ack_s;

  assign pick_en_s = (state_q == IDLE) && (bus.m0_req || bus.m1_req);

  bus_arb_pick #(.STREAK_MAX(STREAK_MAX)) u_pick (
    .clk       (clk),
    .rst       (rst),
    .m0_req_i  (bus.m0_req),
    .m1_req_i  (bus.m1_req),
    .pick_en_i (pick_en_s),
    .winner_o  (winner_s)
  );

  // FSM next-state, request latch, wait counter and completion data
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    req_d   = req_q;
    wait_d  = wait_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    grant_d = grant_q;
    case (state_q)
      IDLE: begin
        if (pick_en_s) begin
          state_d = XFER;
          owner_d = winner_s;
          grant_d = grant_onehot(winner_s);
          wait_d  = '0;
          rdata_d = '0;
          err_d   = 1'b0;
          if (winner_s == M1_DMA) begin
            req_d = '{wr: bus.m1_wr, addr: bus.m1_addr, wdata: bus.m1_wdata};
          end else begin
            req_d = '{wr: bus.m0_wr, addr: bus.m0_addr, wdata: bus.m0_wdata};
          end
        end else begin
          state_d = IDLE;
        end
      end
      XFER: begin
        if (bus.mem_ready) begin
          state_d = ACK;
          rdata_d = req_q.wr ? '0 : bus.mem_rdata;
          err_d   = 1'b0;
        end else if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
          state_d = ACK;
          rdata_d = '0;
          err_d   = 1'b1;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      ACK: begin
        state_d = IDLE;
        grant_d = 2'b00;
      end
      default: begin
        state_d = IDLE;
        grant_d = 2'b00;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= M0_CPU;
      req_q   <= '0;
      wait_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      grant_q <= 2'b00;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      req_q   <= req_d;
      wait_q  <= wait_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      grant_q <= grant_d;
    end
  end

  // Outputs decode straight from registers so reset clears them immediately
  assign in_xfer_s     = (state_q == XFER);
  assign in_ack_s      = (state_q == ACK);
  assign bus.mem_rd    = in_xfer_s && !req_q.wr;
  assign bus.mem_wr    = in_xfer_s && req_q.wr;
  assign bus.mem_addr  = in_xfer_s ? req_q.addr  : '0;
  assign bus.mem_wdata = in_xfer_s ? req_q.wdata : '0;
  assign bus.m0_ack    = in_ack_s && (owner_q == M0_CPU);
  assign bus.m1_ack    = in_ack_s && (owner_q == M1_DMA);
  assign bus.m0_err    = bus.m0_ack && err_q;
  assign bus.m1_err    = bus.m1_ack && err_q;
  assign bus.m0_rdata  = bus.m0_ack ? rdata_q : '0;
  assign bus.m1_rdata  = bus.m1_ack ? rdata_q : '0;
  assign bus.grant     = grant_q;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed vector table, multi-cycle
// corner sequences and randomized transactions against a transaction-level model.
module tb_bus_arbiter;
  import bus_pkg::*;

  localparam int STREAK_MAX = 4;
  localparam int TIMEOUT    = 16;

  logic clk;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   streak_m = 0;

  bus_arbiter_if bif();

  bus_arbiter #(.STREAK_MAX(STREAK_MAX), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        r0, r1, w0, w1;
    logic [31:0] a0, a1, d0, d1, rd;
    int          waits;
    logic [1:0]  egrant;
    logic        eerr;
  } vec_t;

  vec_t vecs[10];
  logic [1:0] order[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bif.m0_req = 1'b0; bif.m0_wr = 1'b0; bif.m0_addr = 32'h0; bif.m0_wdata = 32'h0;
    bif.m1_req = 1'b0; bif.m1_wr = 1'b0; bif.m1_addr = 32'h0; bif.m1_wdata = 32'h0;
    bif.mem_ready = 1'b0; bif.mem_rdata = 32'h0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    streak_m = 0;
  endtask

  // Reference arbitration: lone requester wins; contention goes to M0 until M1 waited STREAK_MAX times
  function automatic logic [1:0] model_grant(input logic r0, input logic r1);
    if (r0 && r1) return (streak_m >= STREAK_MAX) ? 2'b10 : 2'b01;
    else if (r1) return 2'b10;
    else return 2'b01;
  endfunction

  task automatic run_txn(input string tag, input logic r0, input logic r1, input logic w0, input logic w1,
                         input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] d0,
                         input logic [31:0] d1, input logic [31:0] rd, input int waits,
                         input logic [1:0] exp_grant, input logic exp_err);
    logic        ewr;
    logic [31:0] eaddr, ewdata, erdata, ack_rdata;
    int          ncyc;
    ewr    = exp_grant[1] ? w1 : w0;
    eaddr  = exp_grant[1] ? a1 : a0;
    ewdata = exp_grant[1] ? d1 : d0;
    erdata = (ewr || exp_err) ? 32'h0 : rd;
    ncyc   = exp_err ? TIMEOUT : waits + 1;
    if (exp_grant[1] || !r1) streak_m = 0;
    else if (streak_m < STREAK_MAX) streak_m++;

    @(negedge clk);
    bif.m0_req = r0; bif.m0_wr = w0; bif.m0_addr = a0; bif.m0_wdata = d0;
    bif.m1_req = r1; bif.m1_wr = w1; bif.m1_addr = a1; bif.m1_wdata = d1;
    bif.mem_ready = 1'b0;
    @(posedge clk);
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      chk({tag, ".grant"}, 32'(bif.grant), 32'(exp_grant));
      chk({tag, ".busy"}, 32'(bif.busy), 32'd1);
      chk({tag, ".strobe"}, {30'd0, bif.mem_wr, bif.mem_rd}, {30'd0, ewr, !ewr});
      chk({tag, ".addr"}, bif.mem_addr, eaddr);
      if (ewr) chk({tag, ".wdata"}, bif.mem_wdata, ewdata);
      chk({tag, ".early_ack"}, {30'd0, bif.m1_ack, bif.m0_ack}, 32'd0);
      // master-side changes during XFER must not disturb the latched request
      bif.m0_req = 1'b0; bif.m1_req = 1'b0;
      bif.m0_addr = $urandom; bif.m1_addr = $urandom;
      bif.m0_wdata = $urandom; bif.m1_wdata = $urandom;
      bif.m0_wr = 1'($urandom); bif.m1_wr = 1'($urandom);
      bif.mem_ready = (c == waits);
      bif.mem_rdata = (c == waits) ? rd : $urandom;
    end
    @(negedge clk);
    ack_rdata = exp_grant[1] ? bif.m1_rdata : bif.m0_rdata;
    chk({tag, ".ack"}, {30'd0, bif.m1_ack, bif.m0_ack}, 32'(exp_grant));
    chk({tag, ".err"}, {30'd0, bif.m1_err, bif.m0_err}, exp_err ? 32'(exp_grant) : 32'd0);
    chk({tag, ".rdata"}, ack_rdata, erdata);
    chk({tag, ".ack_strobe"}, {30'd0, bif.mem_wr, bif.mem_rd}, 32'd0);
    bif.mem_ready = 1'b0;
    @(negedge clk);
    chk({tag, ".post_ack"}, {30'd0, bif.m1_ack, bif.m0_ack}, 32'd0);
    chk({tag, ".post_busy"}, 32'(bif.busy), 32'd0);
    chk({tag, ".post_grant"}, 32'(bif.grant), 32'd0);
  endtask

  initial begin
    logic r0, r1;
    int   sel, waits;
    logic [1:0] g;

    rst = 1'b1;
    idle_inputs();
    do_reset();

    chk("reset.grant", 32'(bif.grant), 32'd0);
    chk("reset.busy", 32'(bif.busy), 32'd0);
    chk("reset.acks", {28'd0, bif.m1_err, bif.m0_err, bif.m1_ack, bif.m0_ack}, 32'd0);
    chk("reset.strobes", {30'd0, bif.mem_wr, bif.mem_rd}, 32'd0);

    vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h10,  32'h0,   32'h0,        32'h0,    32'hDEADBEEF, 0,  2'b01, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h0,   32'h20,  32'h0,        32'h1234, 32'h5555AAAA, 16, 2'b10, 1'b1};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h300, 32'h0,   32'h0,        32'h0,    32'hCAFE0001, 3,  2'b01, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h400, 32'h500, 32'h0,        32'h99,   32'h11111111, 0,  2'b01, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h404, 32'h504, 32'h0,        32'h98,   32'h22222222, 1,  2'b01, 1'b0};
    vecs[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h408, 32'h508, 32'hA5A5A5A5, 32'h97,   32'h33333333, 2,  2'b01, 1'b0};
    vecs[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h40C, 32'h50C, 32'h0,        32'h0,    32'h44444444, 0,  2'b01, 1'b0};
    vecs[7] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h410, 32'h510, 32'h0,        32'h0,    32'h00000077, 0,  2'b10, 1'b0};
    vecs[8] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h414, 32'h514, 32'h0,        32'h0,    32'h0F0F0F0F, 15, 2'b01, 1'b0};
    vecs[9] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,   32'h518, 32'h0,        32'h0,    32'h12345678, 17, 2'b10, 1'b1};

    for (int i = 0; i < 10; i++) begin
      run_txn($sformatf("vec%0d", i), vecs[i].r0, vecs[i].r1, vecs[i].w0, vecs[i].w1,
              vecs[i].a0, vecs[i].a1, vecs[i].d0, vecs[i].d1, vecs[i].rd,
              vecs[i].waits, vecs[i].egrant, vecs[i].eerr);
    end

    // mem_ready with nobody requesting must not start or complete anything
    @(negedge clk);
    bif.mem_ready = 1'b1;
    bif.mem_rdata = 32'hFEEDF00D;
    repeat (3) begin
      @(negedge clk);
      chk("idle_ready.busy", 32'(bif.busy), 32'd0);
      chk("idle_ready.acks", {30'd0, bif.m1_ack, bif.m0_ack}, 32'd0);
      chk("idle_ready.strobes", {30'd0, bif.mem_wr, bif.mem_rd}, 32'd0);
    end
    bif.mem_ready = 1'b0;

    // Both masters held: grant order shows the starvation bound
    order = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10};
    do_reset();
    bif.m0_req = 1'b1; bif.m1_req = 1'b1; bif.m0_wr = 1'b0; bif.m1_wr = 1'b0;
    bif.mem_ready = 1'b1; bif.mem_rdata = 32'h0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("order%0d", k), 32'(bif.grant), 32'(order[k]));
      @(posedge clk);
      @(posedge clk);
    end
    @(negedge clk);
    bif.m0_req = 1'b0; bif.m1_req = 1'b0; bif.mem_ready = 1'b0;
    @(negedge clk);
    chk("order.idle", 32'(bif.busy), 32'd0);
    streak_m = 0;

    for (int i = 0; i < 60; i++) begin
      sel   = $urandom_range(0, 3);
      r0    = (sel != 1);
      r1    = (sel != 0);
      waits = ($urandom_range(0, 7) == 0) ? $urandom_range(14, 20) : $urandom_range(0, 3);
      g     = model_grant(r0, r1);
      run_txn($sformatf("rnd%0d", i), r0, r1, 1'($urandom), 1'($urandom), $urandom, $urandom,
              $urandom, $urandom, $urandom, waits, g, (waits >= TIMEOUT));
    end

    // Reset in the middle of XFER aborts without an ack
    @(negedge clk);
    bif.m0_req = 1'b1; bif.m0_wr = 1'b0; bif.m0_addr = 32'h44;
    @(posedge clk);
    @(negedge clk);
    chk("rst.pre_rd", 32'(bif.mem_rd), 32'd1);
    bif.m0_req = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("rst.strobes", {30'd0, bif.mem_wr, bif.mem_rd}, 32'd0);
    chk("rst.grant", 32'(bif.grant), 32'd0);
    chk("rst.busy", 32'(bif.busy), 32'd0);
    chk("rst.acks", {30'd0, bif.m1_ack, bif.m0_ack}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    streak_m = 0;
    repeat (3) begin
      @(negedge clk);
      chk("rst.no_ack", {30'd0, bif.m1_ack, bif.m0_ack}, 32'd0);
      chk("rst.idle", 32'(bif.busy), 32'd0);
    end
    run_txn("post_rst", 1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 32'h88, 32'h0, 32'hABCD, 32'h0, 2, 2'b10, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
